io_port_bank: RTL

//  Parametrised memory-mapped I/O port bank for the pipelined computer's MEM stage.
//  - Provides NUM_IN synchronised input ports with sticky change flags.
//  - Provides NUM_OUT writable output registers.
//  - Decodes one 256-byte window at IO_BASE; returns registered read data.
//  - Sits beside the data RAM; the MEM stage muxes rdata when io_hit is high.

---
 rtl/io_port_bank.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped I/O port bank for the MEM stage.
// Provides NUM_IN synchronised input ports with sticky change flags, NUM_OUT
// writable output registers, and one 256-byte window at IO_BASE.
// Optional feature macro: IO_PORT_IRQ_EN adds the IRQ_MASK register and the irq output.
module io_port_bank #(
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'hFFFF_FF00
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      we,
  input  logic                      re,
  output logic                      io_hit,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rvalid,
  input  logic [NUM_IN*DATA_W-1:0]  in_ports,
  output logic [NUM_OUT*DATA_W-1:0] out_ports
`ifdef IO_PORT_IRQ_EN
  ,
  output logic                      irq
`endif
);

  // Address decode: addr[7:6] selects region, addr[5:2] selects the word.
  logic [1:0] region;
  logic [3:0] idx;
  logic       wr_hit;
  logic       rd_hit;
  logic       wr_status;
  logic       unused_addr_bits;

  assign io_hit           = (addr[ADDR_W-1:8] == IO_BASE[ADDR_W-1:8]);
  assign region           = addr[7:6];
  assign idx              = addr[5:2];
  assign wr_hit           = we && io_hit;
  assign rd_hit           = re && io_hit;
  assign wr_status        = wr_hit && (region == 2'b10) && (idx == 4'd0);
  assign unused_addr_bits = ^addr[1:0];

  // Power-up priming: change detection waits until the sync chain is filled.
  logic [1:0] prime_reg;
  logic       primed;
  assign primed = (prime_reg == 2'd3);

  // Saturating prime counter, counts edges after reset release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prime_reg <= 2'd0;
    end else if (prime_reg != 2'd3) begin
      prime_reg <= prime_reg + 2'd1;
    end
  end

  // Input synchronisers and per-port change detection.
  logic [NUM_IN*DATA_W-1:0] s2_flat;
  logic [NUM_IN-1:0]        flag_set;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
      logic [DATA_W-1:0] s1_reg;
      logic [DATA_W-1:0] s2_reg;
      logic [DATA_W-1:0] prev_reg;

      // Two-flop synchroniser plus a previous-value copy for edge detection.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          s1_reg   <= '0;
          s2_reg   <= '0;
          prev_reg <= '0;
        end else begin
          s1_reg   <= in_ports[gi*DATA_W +: DATA_W];
          s2_reg   <= s1_reg;
          prev_reg <= s2_reg;
        end
      end

      assign s2_flat[gi*DATA_W +: DATA_W] = s2_reg;
      assign flag_set[gi]                 = primed && (s2_reg != prev_reg);
    end
  endgenerate

  // Output registers, one per port, each written through its own decode.
  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
      logic [DATA_W-1:0] out_reg;
      logic              wr_sel;
      assign wr_sel = wr_hit && (region == 2'b01) && (idx == 4'(gi));

      // Load the output register on a decoded write.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          out_reg <= '0;
        end else if (wr_sel) begin
          out_reg <= wdata;
        end
      end

      assign out_ports[gi*DATA_W +: DATA_W] = out_reg;
    end
  endgenerate

  // Sticky change flags; a new change on the clearing edge keeps the flag set.
  logic [NUM_IN-1:0] flag_reg;
  logic [NUM_IN-1:0] flag_clr;
  assign flag_clr = {NUM_IN{wr_status}} & wdata[NUM_IN-1:0];

  // Clear-by-write-one, then OR in newly detected changes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      flag_reg <= '0;
    end else begin
      flag_reg <= (flag_reg & ~flag_clr) | flag_set;
    end
  end

`ifdef IO_PORT_IRQ_EN
  logic [NUM_IN-1:0] mask_reg;
  logic              wr_mask;
  assign wr_mask = wr_hit && (region == 2'b10) && (idx == 4'd1);

  // Interrupt mask register and registered interrupt output.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mask_reg <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_mask) begin
        mask_reg <= wdata[NUM_IN-1:0];
      end
      irq <= |(flag_reg & mask_reg);
    end
  end
`endif

  // Read mux: unimplemented indices and offsets return zero.
  logic [DATA_W-1:0] rd_sel;
  always_comb begin
    rd_sel = '0;
    case (region)
      2'b00: begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (idx == 4'(i)) rd_sel = s2_flat[i*DATA_W +: DATA_W];
        end
      end
      2'b01: begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (idx == 4'(i)) rd_sel = out_ports[i*DATA_W +: DATA_W];
        end
      end
      2'b10: begin
        if (idx == 4'd0) rd_sel = DATA_W'(flag_reg);
`ifdef IO_PORT_IRQ_EN
        else if (idx == 4'd1) rd_sel = DATA_W'(mask_reg);
`endif
      end
      default: rd_sel = '0;
    endcase
  end

  // Registered read port; rdata holds between accepted reads.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_hit;
      if (rd_hit) begin
        rdata <= rd_sel;
      end
    end
  end

endmodule
